// File: rtl/kairo_lsu.sv
// kairo_lsu: load/store unit between the execute stage and a word-wide
// request/response memory bus. It accepts one access at a time, raises a bus
// request for aligned accesses, extracts and extends load data, and reports
// completion with DONE (plus MISALIGN for rejected misaligned accesses).
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_start, i_inst_*           access request and one-hot opcode flags
//   i_addr, i_wdata             effective address and store data
//   o_busy                      unit is not idle
//   o_mem_req/we/addr/wstrb/wdata  bus request (word address, lane strobes)
//   i_mem_ready                 bus accepts the request
//   i_mem_rvalid, i_mem_rdata   read response
//   o_wb_valid, o_wb_data       load writeback pulse and data
//   o_done, o_misalign          completion pulse and misaligned flag
`timescale 1ns/1ps
module kairo_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_inst_lb,
  input  logic        i_inst_lh,
  input  logic        i_inst_lw,
  input  logic        i_inst_lbu,
  input  logic        i_inst_lhu,
  input  logic        i_inst_sb,
  input  logic        i_inst_sh,
  input  logic        i_inst_sw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_data,
  output logic        o_done,
  output logic        o_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, FIN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Latched load kind {lhu, lbu, lw, lh, lb} and byte lane of the address
  logic [4:0]  r_ld;
  logic [1:0]  r_lane;

  logic [7:0]  w_ops;
  logic        w_onehot;
  logic        w_accept;
  logic        w_misal;
  logic        w_store;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata_fmt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;

  logic        w_busy_nxt;
  logic        w_mem_req_nxt;
  logic        w_mem_we_nxt;
  logic [31:0] w_mem_addr_nxt;
  logic [3:0]  w_mem_wstrb_nxt;
  logic [31:0] w_mem_wdata_nxt;
  logic        w_wb_valid_nxt;
  logic [31:0] w_wb_data_nxt;
  logic        w_done_nxt;
  logic        w_misalign_nxt;

  // Request decode: exactly one opcode flag, accepted only while idle
  assign w_ops    = {i_inst_sw, i_inst_sh, i_inst_sb, i_inst_lhu,
                     i_inst_lbu, i_inst_lw, i_inst_lh, i_inst_lb};
  assign w_onehot = (w_ops != 8'd0) && ((w_ops & (w_ops - 8'd1)) == 8'd0);
  assign w_accept = (r_state == IDLE) && i_start && w_onehot;
  assign w_store  = i_inst_sb | i_inst_sh | i_inst_sw;
  assign w_misal  = ((i_inst_lh | i_inst_lhu | i_inst_sh) && i_addr[0]) ||
                    ((i_inst_lw | i_inst_sw) && (i_addr[1:0] != 2'b00));

  // Store lane strobes and lane-replicated data
  always_comb begin
    w_strb      = 4'b0000;
    w_wdata_fmt = i_wdata;
    if (i_inst_sb) begin
      w_strb      = 4'b0001 << i_addr[1:0];
      w_wdata_fmt = {4{i_wdata[7:0]}};
    end else if (i_inst_sh) begin
      w_strb      = i_addr[1] ? 4'b1100 : 4'b0011;
      w_wdata_fmt = {2{i_wdata[15:0]}};
    end else if (i_inst_sw) begin
      w_strb      = 4'b1111;
    end
  end

  // Load data extraction and extension
  assign w_byte = i_mem_rdata[{r_lane, 3'b000} +: 8];
  assign w_half = i_mem_rdata[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_ld_data = i_mem_rdata;
    if (r_ld[0])      w_ld_data = {{24{w_byte[7]}}, w_byte};
    else if (r_ld[1]) w_ld_data = {{16{w_half[15]}}, w_half};
    else if (r_ld[3]) w_ld_data = {24'd0, w_byte};
    else if (r_ld[4]) w_ld_data = {16'd0, w_half};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_misal ? FIN : REQ;
      REQ:  if (i_mem_ready) w_state_nxt = (r_ld != 5'd0) ? RESP : FIN;
      RESP: if (i_mem_rvalid) w_state_nxt = FIN;
      FIN:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output next-values; bus fields are frozen from acceptance through REQ
  always_comb begin
    w_busy_nxt      = (w_state_nxt != IDLE);
    w_mem_req_nxt   = (w_state_nxt == REQ);
    w_mem_we_nxt    = 1'b0;
    w_mem_wstrb_nxt = 4'b0000;
    w_mem_addr_nxt  = o_mem_addr;
    w_mem_wdata_nxt = o_mem_wdata;
    w_wb_valid_nxt  = (r_state == RESP) && i_mem_rvalid;
    w_wb_data_nxt   = o_wb_data;
    w_done_nxt      = (w_state_nxt == FIN);
    w_misalign_nxt  = w_accept && w_misal;
    if (w_accept) begin
      w_mem_addr_nxt  = {i_addr[31:2], 2'b00};
      w_mem_wdata_nxt = w_wdata_fmt;
    end
    if (w_state_nxt == REQ) begin
      w_mem_we_nxt    = w_accept ? w_store : o_mem_we;
      w_mem_wstrb_nxt = w_accept ? w_strb  : o_mem_wstrb;
    end
    if (w_wb_valid_nxt) w_wb_data_nxt = w_ld_data;
  end

  // Access context captured on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld   <= 5'd0;
      r_lane <= 2'd0;
    end else if (w_accept) begin
      r_ld   <= {i_inst_lhu, i_inst_lbu, i_inst_lw, i_inst_lh, i_inst_lb};
      r_lane <= i_addr[1:0];
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_busy      <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= 32'd0;
      o_mem_wstrb <= 4'd0;
      o_mem_wdata <= 32'd0;
      o_wb_valid  <= 1'b0;
      o_wb_data   <= 32'd0;
      o_done      <= 1'b0;
      o_misalign  <= 1'b0;
    end else begin
      o_busy      <= w_busy_nxt;
      o_mem_req   <= w_mem_req_nxt;
      o_mem_we    <= w_mem_we_nxt;
      o_mem_addr  <= w_mem_addr_nxt;
      o_mem_wstrb <= w_mem_wstrb_nxt;
      o_mem_wdata <= w_mem_wdata_nxt;
      o_wb_valid  <= w_wb_valid_nxt;
      o_wb_data   <= w_wb_data_nxt;
      o_done      <= w_done_nxt;
      o_misalign  <= w_misalign_nxt;
    end
  end

endmodule

// File: doc/kairo_lsu.md
KAIRO_LSU -- requirements
Module: kairo_lsu

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST_N  input  1  reset, asynchronous and active-low.
REQ-004 START  input  1  execute-stage result valid; samples ADDR, WDATA and the INST_* flags.
REQ-005 INST_LB  input  1  load byte, sign-extended.
REQ-006 INST_LH  input  1  load halfword, sign-extended.
REQ-007 INST_LW  input  1  load word.
REQ-008 INST_LBU  input  1  load byte, zero-extended.
REQ-009 INST_LHU  input  1  load halfword, zero-extended.
REQ-010 INST_SB  input  1  store byte.
REQ-011 INST_SH  input  1  store halfword.
REQ-012 INST_SW  input  1  store word.
REQ-013 ADDR  input  32  effective address (ALU RS1+IMM sum).
REQ-014 WDATA  input  32  store data (RS2).
REQ-015 BUSY  output  1  high in any state other than IDLE.
REQ-016 MEM_REQ  output  1  bus request valid.
REQ-017 MEM_WE  output  1  1 = write, 0 = read.
REQ-018 MEM_ADDR  output  32  word address, equal to {ADDR[31:2],2'b00}.
REQ-019 MEM_WSTRB  output  4  byte-lane write enables.
REQ-020 MEM_WDATA  output  32  lane-replicated store data.
REQ-021 MEM_READY  input  1  bus accepts request when MEM_REQ&MEM_READY.
REQ-022 MEM_RVALID  input  1  read data valid.
REQ-023 MEM_RDATA  input  32  read data word.
REQ-024 WB_VALID  output  1  one-cycle pulse; load result on WB_DATA.
REQ-025 WB_DATA  output  32  aligned, extended load result.
REQ-026 DONE  output  1  one-cycle pulse at completion of any accepted access, including misaligned ones.
REQ-027 MISALIGN  output  1  one-cycle pulse with DONE for a misaligned access.

Function
REQ-028 The FSM SHALL have exactly the states IDLE, REQ, RESP and FIN.
REQ-029 START SHALL be accepted only in IDLE with exactly one INST_* flag high; otherwise it SHALL be ignored with no outputs.
REQ-030 The block SHALL latch the op, ADDR[1:0], MEM_ADDR and WDATA on acceptance, and SHALL NOT track later input changes.
REQ-031 Misaligned means: LH/LHU/SH with ADDR[0]=1, or LW/SW with ADDR[1:0]!=0.
REQ-032 On a misaligned accept: IDLE->FIN; MISALIGN=1 and DONE=1 in the cycle after acceptance; no MEM_REQ; WB_VALID stays 0.
REQ-033 On an aligned accept: IDLE->REQ; MEM_REQ=1 from the next cycle and held with stable ADDR/WE/WSTRB/WDATA until MEM_READY=1.
REQ-034 Store accept (REQ with MEM_READY=1) SHALL go to FIN; DONE pulses the next cycle, with no WB_VALID.
REQ-035 Load accept SHALL go to RESP; MEM_RVALID SHALL be honoured only in RESP and ignored in every other state.
REQ-036 In RESP, MEM_RVALID=1 SHALL capture the extracted data, go to FIN, and pulse WB_VALID and DONE the next cycle.
REQ-037 FIN SHALL return to IDLE unconditionally; a new START is accepted in the cycle FIN is exited, i.e. when back in IDLE.
REQ-038 Minimum latency from START to DONE: 2 cycles for a store; 3 cycles for a load when MEM_RVALID arrives the cycle after acceptance.
REQ-039 MEM_WSTRB for SB SHALL be 4'b0001<<ADDR[1:0]; for SH, 4'b0011 when ADDR[1]=0, else 4'b1100; for SW, 4'b1111; for reads, 4'b0000.
REQ-040 MEM_WDATA for SB SHALL be {4{WDATA[7:0]}}; for SH, {2{WDATA[15:0]}}; for SW, WDATA.
REQ-041 Loads SHALL select the byte at RDATA[8*ADDR[1:0]+:8] or the halfword at RDATA[16*ADDR[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW is a pass-through.
REQ-042 When idle, MEM_REQ, MEM_WE, MEM_WSTRB, WB_VALID, DONE and MISALIGN SHALL be 0, and WB_DATA SHALL hold its last value.

Reset
REQ-043 When RST_N=0, the FSM SHALL go to IDLE immediately and all outputs SHALL be 0, including WB_DATA, MEM_ADDR and MEM_WDATA.
REQ-044 Reset asserted mid-access SHALL abandon the access; no DONE or WB_VALID follows, and a late MEM_RVALID after reset is ignored.

Verification
REQ-045 LB with ADDR=0x1003 and RDATA=0x80112233 -> MEM_ADDR=0x1000, WE=0, WB_DATA=0xFFFFFF80; WB_VALID and DONE pulse 3 cycles after START with zero-wait bus.
REQ-046 SH with ADDR=0x2002 and WDATA=0x0000BEEF -> WSTRB=4'b1100, MEM_WDATA=0xBEEFBEEF; DONE 2 cycles after START; WB_VALID=0.
REQ-047 LW with ADDR=0x3001 -> MISALIGN=1 and DONE=1 one cycle later; MEM_REQ never asserted.
REQ-048 SW with MEM_READY held low for 4 cycles -> MEM_REQ and all bus fields stable for 5 cycles; START pulses during BUSY are ignored.
REQ-049 LHU at 0x4002 with RDATA=0xA5A51234 and a spurious MEM_RVALID in IDLE -> the spurious pulse is ignored; result WB_DATA=0x0000A5A5.
REQ-050 RST_N dropped while in RESP, then MEM_RVALID=1 -> no WB_VALID or DONE; the next LBU completes normally.
